// File: rtl/image_write_sched_if.sv
// Bus bundle between image_write_sched and its cfg master, image_write,
// the layer controller and the bank consumer.
interface image_write_sched_if #(
   parameter int unsigned CFG_DWIDTH = 32,
   parameter int unsigned CFG_AWIDTH = 5
);
   logic [CFG_DWIDTH-1:0] cfg_data;
   logic [CFG_AWIDTH-1:0] cfg_addr;
   logic                  cfg_valid;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic                  wr_next;
   logic                  wr_val_mon;
   logic                  bank_sel;
   logic [1:0]            bank_full;
   logic [1:0]            bank_release;

   modport master (
      output cfg_data, cfg_addr, cfg_valid, start, wr_val_mon, bank_release,
      input  busy, done, err, wr_next, bank_sel, bank_full
   );

   modport slave (
      input  cfg_data, cfg_addr, cfg_valid, start, wr_val_mon, bank_release,
      output busy, done, err, wr_next, bank_sel, bank_full
   );
endinterface

// File: rtl/image_write_sched.sv
// Ping-pong tile scheduler for image_write: issues one next pulse per tile, counts
// wr_val beats to close a tile, marks the bank full and waits for the consumer to free it.
module image_write_sched #(
   parameter int unsigned          CFG_DWIDTH   = 32,
   parameter int unsigned          CFG_AWIDTH   = 5,
   parameter int unsigned          MEM_AWIDTH   = 16,
   parameter logic [CFG_AWIDTH-1:0] CFG_LEN_ADDR = CFG_AWIDTH'(4),
   parameter logic [CFG_AWIDTH-1:0] CFG_NUM_ADDR = CFG_AWIDTH'(5)
) (
   input logic               clk,
   input logic               rst_n,
   image_write_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StWaitBank, StIssue, StFill} state_e;

   state_e                state_q, state_d;
   logic [MEM_AWIDTH-1:0] len_q, len_d, len_run_q, len_run_d, word_cnt_q, word_cnt_d;
   logic [15:0]           num_q, num_d, num_run_q, num_run_d, tile_cnt_q, tile_cnt_d;
   logic                  done_q, done_d, err_q, err_d, bank_sel_q, bank_sel_d;
   logic [1:0]            bank_full_q, bank_full_d;
   logic                  unused_cfg_hi;

   assign unused_cfg_hi = ^bus.cfg_data[CFG_DWIDTH-1:16];

   always_comb begin
      len_d = len_q;
      num_d = num_q;
      if (bus.cfg_valid && bus.cfg_addr == CFG_LEN_ADDR) len_d = bus.cfg_data[MEM_AWIDTH-1:0];
      if (bus.cfg_valid && bus.cfg_addr == CFG_NUM_ADDR) num_d = bus.cfg_data[15:0];
   end

   always_comb begin
      state_d    = state_q;
      len_run_d  = len_run_q;
      num_run_d  = num_run_q;
      word_cnt_d = word_cnt_q;
      tile_cnt_d = tile_cnt_q;
      done_d     = 1'b0;
      err_d      = err_q;
      bank_sel_d = bank_sel_q;
      // Release first so a same-cycle set below overrides it.
      bank_full_d = bank_full_q & ~bus.bank_release;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               err_d = 1'b0;
               if (len_q == '0 || num_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = StWaitBank;
                  tile_cnt_d = '0;
                  len_run_d  = len_q;
                  num_run_d  = num_q;
               end
            end
         end
         StWaitBank: begin
            if (!bank_full_q[bank_sel_q]) state_d = StIssue;
         end
         StIssue: begin
            word_cnt_d = '0;
            state_d    = StFill;
         end
         StFill: begin
            if (bus.wr_val_mon) begin
               word_cnt_d = word_cnt_q + MEM_AWIDTH'(1);
               if (word_cnt_q == len_run_q - MEM_AWIDTH'(1)) begin
                  bank_full_d[bank_sel_q] = 1'b1;
                  bank_sel_d              = ~bank_sel_q;
                  tile_cnt_d              = tile_cnt_q + 16'd1;
                  if (tile_cnt_q == num_run_q - 16'd1) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StWaitBank;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Beats outside a tile are protocol errors and are never counted.
      if (bus.wr_val_mon && state_q != StFill) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         len_q       <= '0;
         num_q       <= '0;
         len_run_q   <= '0;
         num_run_q   <= '0;
         word_cnt_q  <= '0;
         tile_cnt_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         bank_sel_q  <= 1'b0;
         bank_full_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         num_q       <= num_d;
         len_run_q   <= len_run_d;
         num_run_q   <= num_run_d;
         word_cnt_q  <= word_cnt_d;
         tile_cnt_q  <= tile_cnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         bank_sel_q  <= bank_sel_d;
         bank_full_q <= bank_full_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.wr_next   = (state_q == StIssue);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.bank_sel  = bank_sel_q;
   assign bus.bank_full = bank_full_q;

endmodule

// File: tb/tb_image_write_sched.sv
// Self-checking bench for image_write_sched: run/tile-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_image_write_sched;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   image_write_sched_if #(.CFG_DWIDTH(32), .CFG_AWIDTH(5)) bus ();

   image_write_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: tracks a run as tiles and beats rather than controller states.
   int       m_len_r, m_num_r, m_L, m_N, m_beats, m_tiles;
   bit       m_run, m_need, m_open, m_wrn, m_done, m_err, m_sel;
   bit [1:0] m_full;

   task automatic model_reset();
      m_len_r = 0; m_num_r = 0; m_L = 0; m_N = 0; m_beats = 0; m_tiles = 0;
      m_run = 0; m_need = 0; m_open = 0; m_wrn = 0; m_done = 0; m_err = 0; m_sel = 0;
      m_full = 2'b00;
   endtask

   task automatic model_step();
      bit [1:0] full_n;
      bit       done_n, wrn_n, err_n, open_old;
      open_old = m_open;
      full_n   = m_full & ~bus.bank_release;
      done_n   = 0;
      wrn_n    = 0;
      err_n    = m_err;
      if (!m_run) begin
         if (bus.start) begin
            err_n = 0;
            if (m_len_r == 0 || m_num_r == 0) done_n = 1;
            else begin
               m_run = 1; m_need = 1; m_tiles = 0; m_L = m_len_r; m_N = m_num_r;
            end
         end
      end else if (m_need) begin
         if (!m_full[m_sel]) begin m_need = 0; wrn_n = 1; end
      end else if (m_wrn) begin
         m_open = 1; m_beats = 0;
      end else if (bus.wr_val_mon) begin
         m_beats++;
         if (m_beats == m_L) begin
            full_n[m_sel] = 1;
            m_sel  = ~m_sel;
            m_tiles++;
            m_open = 0;
            if (m_tiles == m_N) begin m_run = 0; done_n = 1; end
            else m_need = 1;
         end
      end
      if (bus.wr_val_mon && !open_old) err_n = 1;
      if (bus.cfg_valid && bus.cfg_addr == 5'd4) m_len_r = int'(bus.cfg_data[15:0]);
      if (bus.cfg_valid && bus.cfg_addr == 5'd5) m_num_r = int'(bus.cfg_data[15:0]);
      m_full = full_n; m_done = done_n; m_wrn = wrn_n; m_err = err_n;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      chk("cycle_outputs",
          {25'd0, bus.busy, bus.done, bus.err, bus.wr_next, bus.bank_sel, bus.bank_full},
          {25'd0, m_run, m_done, m_err, m_wrn, m_sel, m_full});
   end

   // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
   task automatic step(input bit st, input bit wv, input bit [1:0] rel, input bit cv = 1'b0,
                       input logic [4:0] ca = '0, input logic [31:0] cd = '0);
      #1;
      bus.start = st; bus.wr_val_mon = wv; bus.bank_release = rel;
      bus.cfg_valid = cv; bus.cfg_addr = ca; bus.cfg_data = cd;
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset(input bit check_vals);
      #1;
      rst_n = 1'b0;
      bus.start = 0; bus.wr_val_mon = 0; bus.bank_release = 0;
      bus.cfg_valid = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      model_reset();
      #1;
      if (check_vals)
         chk("reset_outputs", {25'd0, bus.busy, bus.done, bus.err, bus.wr_next, bus.bank_sel,
                               bus.bank_full}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      model_step();
      @(negedge clk);
   endtask

   task automatic run_tile(input int beats, input string name);
      bit seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         step(0, 0, 2'b00);
         if (bus.wr_next) seen = 1;
      end
      chk({name, "_issue_seen"}, 32'(seen), 32'd1);
      step(0, 0, 2'b00);
      for (int i = 0; i < beats; i++) step(0, 1, 2'b00);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      do_reset(0);

      // Single tile, len=4 num=1: exact wr_next and done timing.
      step(0, 0, 0, 1, 5'd4, 32'd4);
      step(0, 0, 0, 1, 5'd5, 32'd1);
      step(1, 0, 0);
      chk("t2_wrnext_T1", 32'(bus.wr_next), 32'd0);
      step(0, 0, 0);
      chk("t2_wrnext_T2", 32'(bus.wr_next), 32'd1);
      step(0, 0, 0);
      chk("t2_wrnext_T3", 32'(bus.wr_next), 32'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 0);
      chk("t2_done_early", 32'(bus.done), 32'd0);
      step(0, 1, 0);
      chk("t2_done", 32'(bus.done), 32'd1);
      chk("t2_busy", 32'(bus.busy), 32'd0);
      chk("t2_bank_full", 32'(bus.bank_full), 32'd1);
      chk("t2_bank_sel", 32'(bus.bank_sel), 32'd1);
      step(0, 0, 0);
      chk("t2_done_pulse", 32'(bus.done), 32'd0);

      // Three tiles into two banks: stall until bank0 is released.
      do_reset(0);
      step(0, 0, 0, 1, 5'd4, 32'd3);
      step(0, 0, 0, 1, 5'd5, 32'd3);
      step(1, 0, 0);
      run_tile(3, "t3_tile0");
      run_tile(3, "t3_tile1");
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         if (bus.wr_next) cnt++;
      end
      chk("t3_hold_wrnext", 32'(cnt), 32'd0);
      chk("t3_hold_busy", 32'(bus.busy), 32'd1);
      chk("t3_hold_full", 32'(bus.bank_full), 32'd3);
      step(0, 0, 2'b01);
      chk("t3_released", 32'(bus.bank_full), 32'd2);
      chk("t3_wrnext_R1", 32'(bus.wr_next), 32'd0);
      step(0, 0, 0);
      chk("t3_wrnext_R2", 32'(bus.wr_next), 32'd1);
      step(0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0);
      chk("t3_done", 32'(bus.done), 32'd1);
      chk("t3_full", 32'(bus.bank_full), 32'd3);
      chk("t3_sel", 32'(bus.bank_sel), 32'd1);

      // Degenerate runs: num=0, then len=0.
      step(0, 0, 0, 1, 5'd5, 32'd0);
      step(1, 0, 0);
      chk("t4_num0_done", 32'(bus.done), 32'd1);
      chk("t4_num0_busy", 32'(bus.busy), 32'd0);
      chk("t4_num0_wrnext", 32'(bus.wr_next), 32'd0);
      chk("t4_num0_full", 32'(bus.bank_full), 32'd3);
      step(0, 0, 0);
      chk("t4_num0_pulse", 32'(bus.done), 32'd0);
      step(0, 0, 0, 1, 5'd4, 32'd0);
      step(0, 0, 0, 1, 5'd5, 32'd2);
      step(1, 0, 0);
      chk("t4_len0_done", 32'(bus.done), 32'd1);
      chk("t4_len0_busy", 32'(bus.busy), 32'd0);

      // Stray beat sets sticky err; accepted start clears it; starts while busy ignored.
      step(0, 1, 0);
      chk("t5_err_set", 32'(bus.err), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      chk("t5_err_sticky", 32'(bus.err), 32'd1);
      step(0, 0, 2'b11);
      step(0, 0, 0, 1, 5'd4, 32'd2);
      step(0, 0, 0, 1, 5'd5, 32'd1);
      step(1, 0, 0);
      chk("t5_err_clr", 32'(bus.err), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(bus.busy, m_open, 0);
         if (bus.done) cnt++;
      end
      chk("t5_one_done", 32'(cnt), 32'd1);

      // Reset mid-FILL, then a fresh run completes.
      step(0, 0, 0, 1, 5'd4, 32'd3);
      step(0, 0, 0, 1, 5'd5, 32'd2);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      do_reset(1);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         if (bus.done) cnt++;
      end
      chk("t6_no_done", 32'(cnt), 32'd0);
      step(0, 0, 0, 1, 5'd4, 32'd2);
      step(0, 0, 0, 1, 5'd5, 32'd1);
      step(1, 0, 0);
      run_tile(2, "t6_tile");
      chk("t6_done", 32'(bus.done), 32'd1);
      chk("t6_full", 32'(bus.bank_full), 32'd1);
      chk("t6_sel", 32'(bus.bank_sel), 32'd1);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         bit          st, wv, cv;
         bit [1:0]    rel;
         logic [4:0]  ca;
         logic [31:0] cd;
         if ($urandom_range(0, 399) == 0) begin
            do_reset(1);
            continue;
         end
         rel[0] = ($urandom_range(0, 7) == 0);
         rel[1] = ($urandom_range(0, 7) == 0);
         cv = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 2))
            0:       ca = 5'd4;
            1:       ca = 5'd5;
            default: ca = 5'($urandom_range(0, 31));
         endcase
         cd = {16'($urandom), 16'((ca == 5'd4) ? $urandom_range(0, 5) : $urandom_range(0, 3))};
         if (!m_run) begin
            st = ($urandom_range(0, 5) == 0);
            wv = !st && ($urandom_range(0, 19) == 0);
         end else begin
            st = ($urandom_range(0, 9) == 0);
            wv = m_open ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
         end
         step(st, wv, rel, cv, ca, cd);
      end

      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
